// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch unit: FSM state encoding, default widths
// and the constant branch target table.
// Optional feature macro: BRANCH_REL_EN selects PC-relative branch entries.
package fetch_pkg;

   localparam int PC_W_DEF      = 10;
   localparam int LUT_IDX_W_DEF = 5;
   localparam int CYC_W_DEF     = 16;
   localparam int LUT_ENTRIES   = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_RUN    = 2'd2,
      ST_HALTED = 2'd3
   } fetch_state_e;

`ifdef BRANCH_REL_EN
   // Signed offsets added to the current pc; entry i is (i - 5).
   localparam logic signed [15:0] BRANCH_LUT [LUT_ENTRIES] = '{
      -16'sd5,  -16'sd4,  -16'sd3,  -16'sd2,  -16'sd1,  16'sd0,   16'sd1,   16'sd2,
      16'sd3,   16'sd4,   16'sd5,   16'sd6,   16'sd7,   16'sd8,   16'sd9,   16'sd10,
      16'sd11,  16'sd12,  16'sd13,  16'sd14,  16'sd15,  16'sd16,  16'sd17,  16'sd18,
      16'sd19,  16'sd20,  16'sd21,  16'sd22,  16'sd23,  16'sd24,  16'sd25,  16'sd26
   };
`else
   // Absolute targets; entry i is (8*i + 16).
   localparam logic signed [15:0] BRANCH_LUT [LUT_ENTRIES] = '{
      16'sd16,  16'sd24,  16'sd32,  16'sd40,  16'sd48,  16'sd56,  16'sd64,  16'sd72,
      16'sd80,  16'sd88,  16'sd96,  16'sd104, 16'sd112, 16'sd120, 16'sd128, 16'sd136,
      16'sd144, 16'sd152, 16'sd160, 16'sd168, 16'sd176, 16'sd184, 16'sd192, 16'sd200,
      16'sd208, 16'sd216, 16'sd224, 16'sd232, 16'sd240, 16'sd248, 16'sd256, 16'sd264
   };
`endif

endpackage

// File: rtl/fetch_unit_if.sv
// Harness <-> fetch unit bundle. The harness drives the control inputs
// (master); the fetch unit drives the instruction address and status (slave).
interface fetch_unit_if #(
   parameter int PC_W      = 10,
   parameter int LUT_IDX_W = 5,
   parameter int CYC_W     = 16
);
   logic                 start;
   logic                 stall;
   logic                 branch_en;
   logic [LUT_IDX_W-1:0] branch_idx;
   logic                 halt;
   logic [PC_W-1:0]      pc;
   logic                 fetch_valid;
   logic                 done;
   logic [CYC_W-1:0]     run_cycles;

   modport master (
      output start, stall, branch_en, branch_idx, halt,
      input  pc, fetch_valid, done, run_cycles
   );

   modport slave (
      input  start, stall, branch_en, branch_idx, halt,
      output pc, fetch_valid, done, run_cycles
   );
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Purely combinational branch target table. Entries are stored 16 bits wide
// and sign-extended or truncated to the program counter width.
module branch_lut
   import fetch_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
   input  logic [LUT_IDX_W-1:0] idx_i,
   output logic [PC_W-1:0]      entry_o
);

   // Table read; indices beyond the stored table return zero.
   always_comb begin
      entry_o = '0;
      if (int'(idx_i) < LUT_ENTRIES) begin
         entry_o = PC_W'(BRANCH_LUT[idx_i]);
      end else begin
         entry_o = '0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: IDLE/ARMED/RUN/HALTED sequencer that steps the instruction
// address with priority halt > stall > branch > increment, and counts the
// cycles spent running. All outputs are registered.
// Optional feature macro: BRANCH_REL_EN (branch table holds pc-relative offsets).
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int PC_W      = PC_W_DEF,
   parameter int LUT_IDX_W = LUT_IDX_W_DEF,
   parameter int CYC_W     = CYC_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   fetch_unit_if.slave bus
);

   fetch_state_e     state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             fetch_valid_q, fetch_valid_d;
   logic             done_q, done_d;
   logic [CYC_W-1:0] run_cycles_q, run_cycles_d;
   logic [PC_W-1:0]  lut_entry_s;
   logic [PC_W-1:0]  branch_target_s;

   branch_lut #(
      .PC_W      (PC_W),
      .LUT_IDX_W (LUT_IDX_W)
   ) u_branch_lut (
      .idx_i   (bus.branch_idx),
      .entry_o (lut_entry_s)
   );

`ifdef BRANCH_REL_EN
   // Offset added to the current pc; the sum wraps naturally at PC_W bits.
   assign branch_target_s = pc_q + lut_entry_s;
`else
   assign branch_target_s = lut_entry_s;
`endif

   // Next state, next pc / cycle count, and registered status flags.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      run_cycles_d  = run_cycles_q;
      fetch_valid_d = 1'b0;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_ARMED;
            else           state_d = ST_IDLE;
         end
         ST_ARMED: begin
            if (!bus.start) state_d = ST_RUN;
            else            state_d = ST_ARMED;
         end
         ST_RUN: begin
            if (bus.halt) state_d = ST_HALTED;
            else          state_d = ST_RUN;
         end
         ST_HALTED: begin
            if (bus.start) state_d = ST_ARMED;
            else           state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Entering or sitting in ARMED rewinds the program; RUN steps it.
      if ((state_q == ST_ARMED) || (state_d == ST_ARMED)) begin
         pc_d         = '0;
         run_cycles_d = '0;
      end else if (state_q == ST_RUN) begin
         if (run_cycles_q == {CYC_W{1'b1}}) run_cycles_d = run_cycles_q;
         else                               run_cycles_d = run_cycles_q + CYC_W'(1);

         // A stalled branch is dropped, not deferred.
         if (bus.halt)           pc_d = pc_q;
         else if (bus.stall)     pc_d = pc_q;
         else if (bus.branch_en) pc_d = branch_target_s;
         else                    pc_d = pc_q + PC_W'(1);
      end else begin
         pc_d         = pc_q;
         run_cycles_d = run_cycles_q;
      end

      fetch_valid_d = (state_d == ST_RUN);
      done_d        = (state_d == ST_HALTED);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         fetch_valid_q <= 1'b0;
         done_q        <= 1'b0;
         run_cycles_q  <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         done_q        <= done_d;
         run_cycles_q  <= run_cycles_d;
      end
   end

   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.done        = done_q;
   assign bus.run_cycles  = run_cycles_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table drives a PC_W=10 instance,
// and a hand-written sequence drives a PC_W=4 / CYC_W=4 instance for pc wrap,
// counter saturation and halt+reset collision.
module tb_fetch_unit;
   import fetch_pkg::*;

`ifdef BRANCH_REL_EN
   localparam int BT10_IDX3 = 5;    // pc 7 + (-2)
   localparam int BT10_IDX0 = 6;    // pc 11 + (-5)
   localparam int BT4_IDX3  = 15;   // pc 1 + (-2) mod 16
`else
   localparam int BT10_IDX3 = 40;
   localparam int BT10_IDX0 = 16;
   localparam int BT4_IDX3  = 8;    // 40 mod 16
`endif

   logic clk = 1'b0;
   logic rst10;
   logic rst4;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   fetch_unit_if #(.PC_W(10), .LUT_IDX_W(5), .CYC_W(16)) bus10 ();
   fetch_unit_if #(.PC_W(4),  .LUT_IDX_W(5), .CYC_W(4))  bus4 ();

   fetch_unit #(.PC_W(10), .LUT_IDX_W(5), .CYC_W(16)) dut10 (
      .clk   (clk),
      .reset (rst10),
      .bus   (bus10.slave)
   );

   fetch_unit #(.PC_W(4), .LUT_IDX_W(5), .CYC_W(4)) dut4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4.slave)
   );

   typedef struct {
      logic       rst;
      logic       start;
      logic       stall;
      logic       br;
      logic [4:0] idx;
      logic       halt;
      int         pc;
      logic       fv;
      logic       dn;
      int         cyc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic st, input logic b,
                      input int idx, input logic h,
                      input int pc, input logic fv, input logic dn, input int cyc);
      vec_t v;
      v.rst = r; v.start = s; v.stall = st; v.br = b; v.idx = 5'(idx); v.halt = h;
      v.pc = pc; v.fv = fv; v.dn = dn; v.cyc = cyc;
      vecs.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
      end
   endtask

   task automatic step4(input logic r, input logic s, input logic st, input logic b,
                        input int idx, input logic h,
                        input int pc, input int fv, input int dn, input int cyc, input int row);
      rst4 = r; bus4.start = s; bus4.stall = st; bus4.branch_en = b;
      bus4.branch_idx = 5'(idx); bus4.halt = h;
      @(posedge clk); #1;
      chk("pc4", row, int'(bus4.pc), pc);
      chk("valid4", row, int'(bus4.fetch_valid), fv);
      chk("done4", row, int'(bus4.done), dn);
      chk("cycles4", row, int'(bus4.run_cycles), cyc);
   endtask

   initial begin
      rst10 = 1'b1; rst4 = 1'b1;
      bus10.start = 1'b0; bus10.stall = 1'b0; bus10.branch_en = 1'b0;
      bus10.branch_idx = 5'd0; bus10.halt = 1'b0;
      bus4.start = 1'b0; bus4.stall = 1'b0; bus4.branch_en = 1'b0;
      bus4.branch_idx = 5'd0; bus4.halt = 1'b0;

      // reset, then IDLE ignores run-time controls
      add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0, 0);
      // start held three cycles (stall ignored while armed)
      for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
      // release start: first RUN cycle shows pc 0
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0);
      for (int k = 1; k <= 5; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, k, 1'b1, 1'b0, k);
      // halt at pc 5; the halt cycle itself is a RUN cycle
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 5, 1'b0, 1'b1, 6);
      for (int k = 0; k < 20; k++)
         add(1'b0, 1'b0, (k % 2 == 0), (k % 2 == 1), k, 1'b1, 5, 1'b0, 1'b1, 6);
      // restart from HALTED
      add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0);
      for (int k = 1; k <= 7; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, k, 1'b1, 1'b0, k);
      // branch at pc 7 via entry 3
      add(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, BT10_IDX3, 1'b1, 1'b0, 8);
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, BT10_IDX3 + 1, 1'b1, 1'b0, 9);
      // reset mid-run wins over start and halt
      add(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0);
      for (int k = 1; k <= 9; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, k, 1'b1, 1'b0, k);
      // stall beats branch for two cycles; branch is not remembered
      add(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 9, 1'b1, 1'b0, 10);
      add(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0, 9, 1'b1, 1'b0, 11);
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 10, 1'b1, 1'b0, 12);
      add(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 11, 1'b1, 1'b0, 13);
      // branch via entry 0, then halt beats stall and branch
      add(1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, BT10_IDX0, 1'b1, 1'b0, 14);
      add(1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, BT10_IDX0, 1'b0, 1'b1, 15);

      for (int i = 0; i < vecs.size(); i++) begin
         rst10 = vecs[i].rst; bus10.start = vecs[i].start; bus10.stall = vecs[i].stall;
         bus10.branch_en = vecs[i].br; bus10.branch_idx = vecs[i].idx; bus10.halt = vecs[i].halt;
         @(posedge clk); #1;
         chk("pc", i, int'(bus10.pc), vecs[i].pc);
         chk("valid", i, int'(bus10.fetch_valid), int'(vecs[i].fv));
         chk("done", i, int'(bus10.done), int'(vecs[i].dn));
         chk("cycles", i, int'(bus10.run_cycles), vecs[i].cyc);
      end
      rst10 = 1'b1; bus10.start = 1'b0; bus10.halt = 1'b0;
      bus10.stall = 1'b0; bus10.branch_en = 1'b0;

      // narrow instance: pc wrap, counter saturation, halt+reset collision
      step4(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1000);
      step4(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1001);
      step4(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1, 0, 0, 1002);
      for (int k = 1; k <= 17; k++)
         step4(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, k % 16, 1, 0, (k > 15) ? 15 : k, 1002 + k);
      step4(1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, BT4_IDX3, 1, 0, 15, 1020);
      step4(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 0, 0, 0, 1021);
      step4(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1022);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
